// File: rtl/trap_ctrl.sv
// Registered trap arbiter: picks one interrupt or exception, resolves M/S delegation,
// holds a req/ack request to the CSR unit, then runs a timed flush window.
// Optional: define TRAP_CTRL_CNT_EN to add accepted-trap counters exc_cnt / int_cnt.
module trap_ctrl #(
  parameter int XLEN      = 32,
  parameter int NSRC      = 4,
  parameter int FLUSH_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NSRC-1:0]   exc_valid,
  input  logic [NSRC*4-1:0] exc_cause,
  input  logic [NSRC*XLEN-1:0] exc_tval,
  input  logic [XLEN-1:0]   inst_pc,
  input  logic              int_allow,
  input  logic [1:0]        prv_cur,
  input  logic              mstatus_mie,
  input  logic              mstatus_sie,
  input  logic [15:0]       mip,
  input  logic [15:0]       mie,
  input  logic [15:0]       medeleg,
  input  logic [15:0]       mideleg,
  input  logic              trap_ack,
  output logic              trap_req,
  output logic [XLEN-1:0]   trap_cause,
  output logic [XLEN-1:0]   trap_val,
  output logic [XLEN-1:0]   trap_epc,
  output logic [1:0]        trap_prv,
  output logic              flush
`ifdef TRAP_CTRL_CNT_EN
  ,
  output logic [31:0]       exc_cnt,
  output logic [31:0]       int_cnt
`endif
);

  localparam int CW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PEND  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [1:0] PRV_U = 2'd0;
  localparam logic [1:0] PRV_S = 2'd1;
  localparam logic [1:0] PRV_M = 2'd3;

  localparam logic [15:0] INT_MASK = 16'h0AAA;
  localparam logic [15:0] MEI_BIT  = 16'h0800;

  logic [1:0]    state;
  logic [CW-1:0] flush_cnt;

  logic [15:0] int_pend;
  logic [15:0] int_deleg;
  logic [15:0] int_en;
  logic        int_hit;
  logic [3:0]  int_code;

  logic            exc_hit;
  logic [3:0]      exc_code;
  logic [XLEN-1:0] exc_tv;

  logic            cand;
  logic            deleg;
  logic [XLEN-1:0] nxt_cause;
  logic [XLEN-1:0] nxt_val;
  logic [1:0]      nxt_prv;

  // MEI can never be delegated, so its mideleg bit is masked off everywhere.
  always_comb begin
    int_pend  = mip & mie & INT_MASK;
    int_deleg = mideleg & ~MEI_BIT;
    for (int k = 0; k < 16; k++) begin
      if (int_deleg[k])
        int_en[k] = int_pend[k] && (prv_cur != PRV_M) && ((prv_cur == PRV_U) || mstatus_sie);
      else
        int_en[k] = int_pend[k] && ((prv_cur != PRV_M) || mstatus_mie);
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    int_hit  = int_allow && (|int_en);
    int_code = 4'd0;
    if      (int_en[11]) int_code = 4'd11;
    else if (int_en[3])  int_code = 4'd3;
    else if (int_en[7])  int_code = 4'd7;
    else if (int_en[9])  int_code = 4'd9;
    else if (int_en[1])  int_code = 4'd1;
    else if (int_en[5])  int_code = 4'd5;
  end

  // Scan from the top so the lowest valid index overwrites last and wins.
  always_comb begin
    exc_hit  = 1'b0;
    exc_code = 4'd0;
    exc_tv   = '0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (exc_valid[i]) begin
        exc_hit  = 1'b1;
        exc_code = exc_cause[4*i +: 4];
        exc_tv   = exc_tval[XLEN*i +: XLEN];
      end
    end
  end

  always_comb begin
    cand = int_hit || exc_hit;
    if (int_hit) begin
      nxt_cause = {1'b1, {(XLEN-5){1'b0}}, int_code};
      nxt_val   = '0;
      deleg     = int_deleg[int_code];
    end else begin
      nxt_cause = {{(XLEN-4){1'b0}}, exc_code};
      nxt_val   = exc_tv;
      deleg     = medeleg[exc_code];
    end
    nxt_prv = (deleg && (prv_cur <= PRV_S)) ? PRV_S : PRV_M;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      flush_cnt  <= '0;
      trap_req   <= 1'b0;
      trap_cause <= '0;
      trap_val   <= '0;
      trap_epc   <= '0;
      trap_prv   <= 2'd0;
      flush      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cand) begin
            state      <= PEND;
            trap_req   <= 1'b1;
            trap_cause <= nxt_cause;
            trap_val   <= nxt_val;
            trap_epc   <= inst_pc;
            trap_prv   <= nxt_prv;
          end
        end
        PEND: begin
          if (trap_ack) begin
            state     <= FLUSH;
            trap_req  <= 1'b0;
            flush     <= 1'b1;
            flush_cnt <= CW'(FLUSH_CYC - 1);
          end
        end
        FLUSH: begin
          if (flush_cnt == '0) begin
            state <= IDLE;
            flush <= 1'b0;
          end else begin
            flush_cnt <= flush_cnt - CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef TRAP_CTRL_CNT_EN
  // A trap counts as accepted on the ack edge; the cause MSB tells interrupts apart.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exc_cnt <= '0;
      int_cnt <= '0;
    end else if (state == PEND && trap_ack) begin
      if (trap_cause[XLEN-1]) int_cnt <= int_cnt + 32'd1;
      else                    exc_cnt <= exc_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
Registered trap arbiter for the core pipeline. It collects exceptions from NSRC pipeline sources and the pending/enabled interrupt vector, then resolves priority and M/S delegation. It issues one held trap request to the CSR unit with a req/ack handshake, followed by a timed pipeline flush window. It is the sequential, multi-source, interrupt- and delegation-aware successor to the combinational trap-cause logic in the execute stage.

Parameters:
XLEN, 32, datapath width of cause/tval/epc
NSRC, 4, number of exception sources; index 0 is highest priority
FLUSH_CYC, 2, cycles flush stays asserted after ack (min 1)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-high reset
exc_valid  in  NSRC  per-source exception valid
exc_cause  in  NSRC*4  per-source exception code 0..15; slot i is bits [4i+3:4i]
exc_tval  in  NSRC*XLEN  per-source trap value; slot i is bits [XLEN*i+XLEN-1:XLEN*i]
inst_pc  in  XLEN  pc of the instruction at the trap point
int_allow  in  1  instruction boundary; interrupts may be taken
prv_cur  in  2  current privilege (0=U, 1=S, 3=M)
mstatus_mie  in  1  M global interrupt enable
mstatus_sie  in  1  S global interrupt enable
mip  in  16  pending interrupts
mie  in  16  interrupt enables
medeleg  in  16  exception delegation
mideleg  in  16  interrupt delegation
trap_ack  in  1  CSR unit has accepted the trap
trap_req  out  1  trap pending, held until ack
trap_cause  out  XLEN  mcause/scause value; bit XLEN-1 set for interrupts
trap_val  out  XLEN  tval; 0 for interrupts
trap_epc  out  XLEN  captured inst_pc
trap_prv  out  2  target privilege (1=S, 3=M)
flush  out  1  pipeline flush

Behaviour:
- FSM states: IDLE, PEND, FLUSH. Reset enters IDLE; every output is 0; flush counter is 0. Reset mid-PEND or mid-FLUSH abandons the trap.
- IDLE: evaluates candidates every cycle. On a candidate at edge T: capture all outputs, go to PEND, trap_req=1 from T+1 (1-cycle latency). With no candidate, remain in IDLE.
- Interrupt candidate: only when int_allow=1. Set p = mip & mie & 16'h0AAA. Interrupt bit k is enabled when:
  - mideleg[k]=0 and (prv_cur<3 or mstatus_mie); or
  - mideleg[k]=1 and prv_cur!=3 and (prv_cur<1 or mstatus_sie).
- Interrupt priority among enabled bits: 11 > 3 > 7 > 9 > 1 > 5.
- Arbitration: an interrupt beats any exception in the same cycle; the faulting instruction is not retired.
- Exception candidate: the lowest index i with exc_valid[i]=1. Its cause and tval are used; the other sources are ignored that cycle.
- Target privilege: S if the delegation bit for the cause is set and prv_cur<=1; otherwise M. Bits 1..15 of cause apply for interrupts (bit 11 is never delegated; MEI is always taken in M).
- trap_cause:
  - interrupt: {1'b1, (XLEN-5)'b0, code[3:0]}
  - exception: zero-extended code
- trap_val: 0 for interrupts.
- PEND: trap_req and all payload outputs held stable. New exc/int inputs are ignored. On trap_ack=1: trap_req drops next cycle, flush=1, go to FLUSH, counter loads FLUSH_CYC-1.
- trap_ack is ignored in IDLE and FLUSH. trap_ack sampled in the same cycle the request is captured has no effect, because req becomes visible at T+1.
- FLUSH: flush=1 and candidates are ignored. The counter decrements each cycle; at 0, go to IDLE with flush=0. flush is high for exactly FLUSH_CYC cycles.
- Back-to-back: a candidate present in the first IDLE cycle after FLUSH is captured at once.
- Payload outputs retain their last values in IDLE and FLUSH. Only trap_req indicates validity.

Optional Feature:
- Macro: TRAP_CTRL_CNT_EN.
- When defined, adds two output ports: exc_cnt (32) and int_cnt (32). Each counts traps accepted (trap_ack in PEND) of that type. Both reset to 0 and wrap from 32'hFFFF_FFFF to 0.
- When undefined, the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Exception arbitration: prv=M, exc_valid=4'b0110, slot1 cause 2 tval 32'hDEAD_BEEF, slot2 cause 8, inst_pc=32'h8000_0100 -> next cycle trap_req=1, cause=2, val=32'hDEAD_BEEF, epc=32'h8000_0100, prv=3.
- Handshake and flush: hold trap_ack=0 for 5 cycles -> payload stable. Ack pulse -> trap_req=0 next cycle, flush high exactly 2 cycles (FLUSH_CYC=2). An exc_valid asserted during FLUSH is not captured.
- Interrupt priority: prv=U, mip=mie=16'h0888, int_allow=1, simultaneous exc cause 2 -> cause=32'h8000_000B, val=0, prv=3.
- Delegation:
  - prv=U, medeleg[8]=1, exc cause 8 -> prv=1.
  - Same with prv=M -> prv=3.
  - prv=M, mideleg[5]=1, mip=mie=16'h0020 -> no trap.
- Global enable: prv=M, mstatus_mie=0, MTI pending -> no trap. Set mstatus_mie=1 -> cause=32'h8000_0007. int_allow=0 -> no trap.
- Reset mid-PEND: assert rst while trap_req=1 -> all outputs 0 immediately. With TRAP_CTRL_CNT_EN, three acked exceptions plus one acked interrupt -> exc_cnt=3, int_cnt=1.
